// File: rtl/key_pkg.sv
// Shared constants for the switch front-end: FSM encoding, default 50 MHz
// cycle counts and the short cycle counts used in simulation.
package key_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    localparam int DEB_CYC_DEF  = 500000;
    localparam int LONG_CYC_DEF = 50000000;
    localparam int REP_CYC_DEF  = 10000000;

    localparam int DEB_CYC_SIM  = 4;
    localparam int LONG_CYC_SIM = 20;
    localparam int REP_CYC_SIM  = 5;

    // Counter width that never collapses to zero bits for a count of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One switch channel: two-flop synchronizer, counter debouncer and the
// press / long-press / auto-repeat event FSM.
module key_chan
    import key_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int REP_CYC  = REP_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic level,
    output logic press_evt,
    output logic release_evt,
    output logic long_evt,
    output logic repeat_evt
);

    localparam int DW = cnt_w(DEB_CYC);
    localparam int HW = cnt_w(LONG_CYC);
    localparam int RW = cnt_w(REP_CYC) + 1;

    logic          sync1_r;
    logic          sync2_r;
    logic [DW-1:0] deb_cnt_r;
    logic [1:0]    state_r;
    logic [HW-1:0] hold_cnt_r;
    logic [RW-1:0] rep_cnt_r;

    logic pressed_s;
    logic flip_s;
    logic acc_press_s;
    logic acc_release_s;

    // Accepted level changes; the raw switch is active-low.
    always_comb begin
        pressed_s     = ~sync2_r;
        flip_s        = (pressed_s != level) && (deb_cnt_r == DW'(DEB_CYC - 1));
        acc_press_s   = flip_s && pressed_s;
        acc_release_s = flip_s && !pressed_s;
    end

    // Synchronizer and debouncer; the stable level is the registered o_level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            deb_cnt_r <= '0;
            level     <= 1'b0;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
            if (pressed_s == level) begin
                deb_cnt_r <= '0;
            end else if (flip_s) begin
                deb_cnt_r <= '0;
                level     <= pressed_s;
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end
    end

    // Event FSM; an accepted release always beats a long/repeat threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= '0;
            rep_cnt_r   <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            long_evt    <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            long_evt    <= 1'b0;
            repeat_evt  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (acc_press_s) begin
                        press_evt  <= 1'b1;
                        repeat_evt <= 1'b1;
                        hold_cnt_r <= '0;
                        state_r    <= ST_PRESSED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (acc_release_s) begin
                        release_evt <= 1'b1;
                        hold_cnt_r  <= '0;
                        state_r     <= ST_IDLE;
                    end else if (hold_cnt_r == HW'(LONG_CYC - 1)) begin
                        long_evt   <= 1'b1;
                        repeat_evt <= 1'b1;
                        hold_cnt_r <= '0;
                        rep_cnt_r  <= '0;
                        state_r    <= ST_HELD;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                ST_HELD: begin
                    if (acc_release_s) begin
                        release_evt <= 1'b1;
                        rep_cnt_r   <= '0;
                        state_r     <= ST_IDLE;
                    end else if (rep_cnt_r == RW'(REP_CYC - 1)) begin
                        repeat_evt <= 1'b1;
                        rep_cnt_r  <= '0;
                    end else begin
                        rep_cnt_r <= rep_cnt_r + RW'(1);
                    end
                end
                default: begin
                    hold_cnt_r <= '0;
                    rep_cnt_r  <= '0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Switch front-end for the digital clock: one independent key_chan per
// raw active-low push-button.
module key_event_gen
    import key_pkg::*;
#(
    parameter int NUM_SW   = 4,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int REP_CYC  = REP_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] i_sw,
    output logic [NUM_SW-1:0] o_level,
    output logic [NUM_SW-1:0] o_press,
    output logic [NUM_SW-1:0] o_release,
    output logic [NUM_SW-1:0] o_long,
    output logic [NUM_SW-1:0] o_repeat
);

    for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
        key_chan #(
            .DEB_CYC (DEB_CYC),
            .LONG_CYC(LONG_CYC),
            .REP_CYC (REP_CYC)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .sw_raw     (i_sw[g]),
            .level      (o_level[g]),
            .press_evt  (o_press[g]),
            .release_evt(o_release[g]),
            .long_evt   (o_long[g]),
            .repeat_evt (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen with the short simulation cycle counts.
module tb_key_event_gen;
    import key_pkg::*;

    localparam int NSW = 4;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NSW-1:0] i_sw;
    logic [NSW-1:0] o_level, o_press, o_release, o_long, o_repeat;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } evt_t;

    evt_t           sb[$];
    int             edge_n = 0;
    int             n_checks = 0;
    int             n_fail = 0;
    int             rst_edge = -1;
    logic [NSW-1:0] exp_level = '0;

    key_event_gen #(
        .NUM_SW  (NSW),
        .DEB_CYC (DEB_CYC_SIM),
        .LONG_CYC(LONG_CYC_SIM),
        .REP_CYC (REP_CYC_SIM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sw     (i_sw),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long),
        .o_repeat (o_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, act, exp);
        end
    endtask

    task automatic expect_evt(input int cyc, input int ch, input int kind);
        sb.push_back('{cyc, ch, kind});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // Pull this edge's expected events out of the scoreboard and compare all outputs.
    always @(negedge clk) begin : monitor
        logic [NSW-1:0] ep, er, el, et;
        ep = '0; er = '0; el = '0; et = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edge_n) begin
                case (sb[i].kind)
                    K_PRESS: ep[sb[i].ch] = 1'b1;
                    K_REL:   er[sb[i].ch] = 1'b1;
                    K_LONG:  el[sb[i].ch] = 1'b1;
                    default: et[sb[i].ch] = 1'b1;
                endcase
                sb.delete(i);
            end
        end
        if (edge_n == rst_edge) exp_level = '0;
        exp_level = (exp_level | ep) & ~er;
        check("press",   32'(o_press),   32'(ep));
        check("release", 32'(o_release), 32'(er));
        check("long",    32'(o_long),    32'(el));
        check("repeat",  32'(o_repeat),  32'(et));
        check("level",   32'(o_level),   32'(exp_level));
    end

    initial begin
        int t0;
        int x;
        rst_n = 1'b0;
        i_sw  = '1;
        wait_cyc(3);
        check("reset_outs", 32'({o_level, o_press, o_release, o_long, o_repeat}), 32'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean tap on channel 0.
        t0 = edge_n + 1;
        expect_evt(t0 + 5, 0, K_PRESS);
        expect_evt(t0 + 5, 0, K_REP);
        expect_evt(t0 + 17, 0, K_REL);
        i_sw[0] = 1'b0;
        wait_cyc(12);
        i_sw[0] = 1'b1;
        wait_cyc(25);

        // Bounce on channel 1, then a short steady press.
        t0 = edge_n + 1;
        expect_evt(t0 + 21, 1, K_PRESS);
        expect_evt(t0 + 21, 1, K_REP);
        expect_evt(t0 + 31, 1, K_REL);
        for (int k = 0; k < 4; k++) begin
            i_sw[1] = 1'b0;
            wait_cyc(2);
            i_sw[1] = 1'b1;
            wait_cyc(2);
        end
        i_sw[1] = 1'b0;
        wait_cyc(10);
        i_sw[1] = 1'b1;
        wait_cyc(25);

        // Long hold on channel 2 with auto-repeat.
        t0 = edge_n + 1;
        expect_evt(t0 + 5, 2, K_PRESS);
        expect_evt(t0 + 5, 2, K_REP);
        expect_evt(t0 + 25, 2, K_LONG);
        expect_evt(t0 + 25, 2, K_REP);
        for (int c = 30; c <= 60; c += 5) expect_evt(t0 + c, 2, K_REP);
        expect_evt(t0 + 65, 2, K_REL);
        i_sw[2] = 1'b0;
        wait_cyc(60);
        i_sw[2] = 1'b1;
        wait_cyc(25);

        // Release lands on the long-press threshold edge of channel 3.
        t0 = edge_n + 1;
        expect_evt(t0 + 5, 3, K_PRESS);
        expect_evt(t0 + 5, 3, K_REP);
        expect_evt(t0 + 25, 3, K_REL);
        i_sw[3] = 1'b0;
        wait_cyc(20);
        i_sw[3] = 1'b1;
        wait_cyc(30);

        // Reset while channel 0 is in HELD, switch kept pressed.
        t0 = edge_n + 1;
        expect_evt(t0 + 5, 0, K_PRESS);
        expect_evt(t0 + 5, 0, K_REP);
        expect_evt(t0 + 25, 0, K_LONG);
        expect_evt(t0 + 25, 0, K_REP);
        expect_evt(t0 + 30, 0, K_REP);
        i_sw[0] = 1'b0;
        wait_cyc(32);
        x = edge_n + 1;
        rst_edge = x;
        rst_n = 1'b0;
        wait_cyc(1);
        check("midrst_outs", 32'({o_level, o_press, o_release, o_long, o_repeat}), 32'd0);
        rst_n = 1'b1;
        expect_evt(x + 6, 0, K_PRESS);
        expect_evt(x + 6, 0, K_REP);
        expect_evt(x + 16, 0, K_REL);
        wait_cyc(10);
        i_sw[0] = 1'b1;
        wait_cyc(25);

        // Staggered presses on all channels.
        t0 = edge_n + 1;
        for (int k = 0; k < NSW; k++) begin
            expect_evt(t0 + k + 5, k, K_PRESS);
            expect_evt(t0 + k + 5, k, K_REP);
            expect_evt(t0 + k + 15, k, K_REL);
        end
        for (int k = 0; k < NSW; k++) begin
            i_sw[k] = 1'b0;
            wait_cyc(1);
        end
        wait_cyc(6);
        for (int k = 0; k < NSW; k++) begin
            i_sw[k] = 1'b1;
            wait_cyc(1);
        end
        wait_cyc(25);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Switch front-end for the digital clock. It turns the four raw, active-low push-buttons into clean single-cycle event pulses (press, release, long-press, auto-repeat) plus a debounced level. It sits between the board switches and the mode/position/set/alarm-enable controller, replacing the slow-clock two-flop filter with a full-rate, counter-based debouncer. Auto-repeat lets a held "set" key step seconds or minutes continuously.

## Interface
- NUM_SW, 4, number of independent switch channels
- DEB_CYC, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥2
- LONG_CYC, 50000000, held cycles after press before long-press is declared (1 s); must be ≥1
- REP_CYC, 10000000, auto-repeat period once long-press is declared (200 ms); must be ≥1
- clk  in  1  system clock, 50 MHz; the only clock
- rst_n  in  1  reset, synchronous, active-low
- i_sw  in  NUM_SW  raw switches, asynchronous, 0 = pressed
- o_level  out  NUM_SW  debounced level, 1 = pressed
- o_press  out  NUM_SW  one-cycle pulse on accepted press
- o_release  out  NUM_SW  one-cycle pulse on accepted release
- o_long  out  NUM_SW  one-cycle pulse when hold reaches LONG_CYC
- o_repeat  out  NUM_SW  one-cycle pulse: with o_press, then periodically while held long

## Operation
- Each channel is independent. There is no cross-channel interaction.
- Synchronizer: two flops per channel.
  - Reset value is 1 (released).
  - The stage-2 output is the filtered sample.
- Debounce:
  - A register holds the stable level, reset to released.
  - If the sample differs from the stable level, the counter increments.
  - If the sample equals the stable level, the counter clears to 0.
  - When the sample differs and the counter is DEB_CYC-1, the stable level flips and the counter clears.
  - Counter width is $clog2(DEB_CYC).
- Per-channel FSM, reset to IDLE:
  - IDLE: on accepted press, pulse o_press and o_repeat, clear the hold counter, go to PRESSED.
  - PRESSED: the hold counter increments each cycle. When it reaches LONG_CYC-1, pulse o_long and o_repeat, clear the repeat counter, go to HELD. On accepted release, pulse o_release, go to IDLE.
  - HELD: the repeat counter counts 0..REP_CYC-1 and wraps. Pulse o_repeat on each wrap. On accepted release, pulse o_release, go to IDLE.
- Hold counter width is $clog2(LONG_CYC). Repeat counter width is $clog2(REP_CYC)+1.
- Boundary conditions:
  - Release accepted in the same cycle the long or repeat threshold is reached: release wins. No o_long or o_repeat is issued.
  - Glitches shorter than DEB_CYC cycles at the synchronizer output produce no event.
  - A switch held through reset is seen as a fresh press after the standard latency once reset deasserts.
  - Reset asserted mid-hold: next cycle all outputs are 0, FSM is IDLE, and counters are 0. No o_release is emitted.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Edge 0 is the first clock edge that samples a new raw level into synchronizer stage 1.
- o_level changes, and o_press or o_release is high, in the cycle after edge DEB_CYC+1. Latency is DEB_CYC+1 edges.
- The first o_long and o_repeat follow o_press by exactly LONG_CYC cycles.
- Subsequent o_repeat pulses are spaced exactly REP_CYC cycles apart.
- Pulses are exactly one cycle wide. o_press and o_release never coincide on one channel.

## Structure
- Shared package key_pkg:
  - FSM state encoding: IDLE=2'd0, PRESSED=2'd1, HELD=2'd2.
  - Default cycle constants for 50 MHz.
  - Simulation constants: DEB_CYC=4, LONG_CYC=20, REP_CYC=5.
- One sub-module, key_chan: synchronizer, debouncer, FSM and counters for one switch. It is instantiated NUM_SW times by a generate loop.
- Top level is wiring only.

## Test plan
All scenarios use simulation parameters (DEB_CYC=4, LONG_CYC=20, REP_CYC=5).
- Clean tap: i_sw[0] low at edge 0 for 12 cycles, then high. Response: o_press[0] pulses after edge 5, o_release[0] pulses 12 cycles later, no o_long.
- Bounce: i_sw[1] toggles every 2 cycles for 16 cycles, then stays low. Response: exactly one o_press[1], 5 edges after the final fall, and no event during bouncing.
- Long hold: i_sw[2] low from edge 0 for 60 cycles. Response:
  - o_press and o_repeat after edge 5.
  - o_long and o_repeat after edge 25.
  - o_repeat after edges 30, 35, 40, … up to the release.
  - One o_release; no repeat on or after release.
- Threshold race: the release flip lands on the same edge the hold counter hits LONG_CYC-1. Response: o_release only, with o_long and o_repeat absent.
- Reset mid-hold: rst_n low for 1 cycle while a channel is in HELD, switch still pressed. Response:
  - All outputs 0 the next cycle.
  - o_press again DEB_CYC+1 edges after the first post-reset sample.
  - No o_release.
- Independence: all four switches pressed with staggered starts 0/1/2/3. Response: o_press on each channel exactly 1 cycle apart, with no cross-talk.
